uart_mmio: RTL and testbench

Memory-mapped UART peripheral on the IO side of the CPU memory bus, selected when address bit 22 is set.
- Consumes the IO-side strobe interface: address, read strobe, write mask, write data. Returns read data.
- Serialises CPU-written bytes onto tx_o as 8N1 frames through a small TX FIFO.
- Exposes a status register for software polling. An optional RX path is included.

---
 rtl/uart_pkg.sv | 18 +
 rtl/sync_fifo.sv | 55 +++++
 rtl/uart_mmio.sv | 254 +++++++++++++++++++++++++
 tb/tb_uart_mmio.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the uart_mmio peripheral: register offsets,
// STATUS bit positions and the TX/RX state encodings.
package uart_pkg;

  localparam logic [1:0] REG_DATA   = 2'd0;
  localparam logic [1:0] REG_STATUS = 2'd1;

  localparam int ST_TX_FULL  = 0;
  localparam int ST_TX_IDLE  = 1;
  localparam int ST_RX_VALID = 2;
  localparam int ST_TX_OVF   = 3;
  localparam int ST_RX_OVF   = 4;
  localparam int ST_RX_FERR  = 5;

  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

endpackage

// File: rtl/sync_fifo.sv
// Synchronous first-word-fall-through FIFO with count-based full/empty.
// DEPTH must be a power of two so the pointers wrap naturally.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [AW:0]      count;
  logic             do_push, do_pop;

  assign full     = (count == (AW+1)'(DEPTH));
  assign empty    = (count == '0);
  assign do_pop   = pop && !empty;
  // A push into a full FIFO still lands when a pop frees a slot this cycle.
  assign do_push  = push && (!full || do_pop);
  assign pop_data = mem[rd_ptr];

  // NOTE: storage is deliberately not reset; only the pointers and count
  // define validity, and a reset-free array maps onto plain RAM/regfile cells.
  always_ff @(posedge clk_i) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/uart_mmio.sv
// Memory-mapped 8N1 UART: DATA/STATUS registers, TX FIFO and serialiser.
// Optional receiver is built when the UART_RX_EN macro is defined.
module uart_mmio
  import uart_pkg::*;
#(
  parameter int CLK_FREQ_HZ   = 50000000,
  parameter int BAUD_RATE     = 115200,
  parameter int TX_FIFO_DEPTH = 4
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic [31:0] addr_i,
  input  logic        rstrb_i,
  output logic [31:0] rdata_o,
  input  logic [3:0]  wmask_i,
  input  logic [31:0] wdata_i,
  output logic        tx_o,
  input  logic        rx_i
);

  localparam int DIV = CLK_FREQ_HZ / BAUD_RATE;
  localparam int BW  = $clog2(DIV);
  localparam logic [BW-1:0] BAUD_LAST = BW'(DIV - 1);

  logic [1:0] reg_sel;
  logic       data_wr, status_wr, data_rd;
  logic       fifo_pop, fifo_full, fifo_empty;
  logic [7:0] fifo_data;
  logic       tx_ovf, tx_idle, tx_drop;
  logic       rx_valid, rx_ovf, rx_ferr;
  logic [7:0] rx_byte;
  logic [31:0] rd_mux;

  assign reg_sel   = addr_i[3:2];
  assign data_wr   = wmask_i[0] && (reg_sel == REG_DATA);
  assign status_wr = wmask_i[0] && (reg_sel == REG_STATUS);
  assign data_rd   = rstrb_i && (reg_sel == REG_DATA);

  logic unused_bus;
  assign unused_bus = &{1'b0, addr_i[31:4], addr_i[1:0], wmask_i[3:1], wdata_i[31:8]};

  sync_fifo #(.WIDTH(8), .DEPTH(TX_FIFO_DEPTH)) u_tx_fifo (
    .clk_i     (clk_i),
    .rst_n_i   (rst_n_i),
    .push      (data_wr),
    .push_data (wdata_i[7:0]),
    .pop       (fifo_pop),
    .pop_data  (fifo_data),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  // ---------------- TX serialiser ----------------
  tx_state_t   tx_state, tx_state_nx;
  logic [BW-1:0] baud_cnt, baud_cnt_nx;
  logic [2:0]  bit_cnt, bit_cnt_nx;
  logic [7:0]  shift, shift_nx;
  logic        tx_bit, baud_tick;

  assign baud_tick = (baud_cnt == BAUD_LAST);

  // NOTE: every output of this block gets a default first, so no path
  // through the case leaves a signal unassigned and no latch is inferred.
  always_comb begin
    tx_state_nx = tx_state;
    baud_cnt_nx = baud_cnt + 1'b1;
    bit_cnt_nx  = bit_cnt;
    shift_nx    = shift;
    fifo_pop    = 1'b0;
    tx_bit      = 1'b1;
    case (tx_state)
      TX_IDLE: begin
        baud_cnt_nx = '0;
        if (!fifo_empty) begin
          fifo_pop    = 1'b1;
          shift_nx    = fifo_data;
          tx_state_nx = TX_START;
        end
      end
      TX_START: begin
        tx_bit = 1'b0;
        if (baud_tick) begin
          baud_cnt_nx = '0;
          bit_cnt_nx  = '0;
          tx_state_nx = TX_DATA;
        end
      end
      TX_DATA: begin
        tx_bit = shift[0];
        if (baud_tick) begin
          baud_cnt_nx = '0;
          shift_nx    = {1'b0, shift[7:1]};
          bit_cnt_nx  = bit_cnt + 1'b1;
          if (bit_cnt == 3'd7) tx_state_nx = TX_STOP;
        end
      end
      TX_STOP: begin
        if (baud_tick) begin
          baud_cnt_nx = '0;
          // Chain straight into the next start bit to keep frames contiguous.
          if (!fifo_empty) begin
            fifo_pop    = 1'b1;
            shift_nx    = fifo_data;
            tx_state_nx = TX_START;
          end else begin
            tx_state_nx = TX_IDLE;
          end
        end
      end
      default: tx_state_nx = TX_IDLE;
    endcase
  end

  // tx_o is the registered line level of the current state, one cycle behind.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      tx_state <= TX_IDLE;
      baud_cnt <= '0;
      bit_cnt  <= '0;
      shift    <= '0;
      tx_o     <= 1'b1;
    end else begin
      tx_state <= tx_state_nx;
      baud_cnt <= baud_cnt_nx;
      bit_cnt  <= bit_cnt_nx;
      shift    <= shift_nx;
      tx_o     <= tx_bit;
    end
  end

  assign tx_idle = fifo_empty && (tx_state == TX_IDLE);
  assign tx_drop = data_wr && fifo_full && !fifo_pop;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) tx_ovf <= 1'b0;
    else          tx_ovf <= (tx_ovf && !(status_wr && wdata_i[ST_TX_OVF])) || tx_drop;
  end

  // ---------------- RX path ----------------
`ifdef UART_RX_EN
  localparam logic [BW-1:0] HALF_LAST = BW'(DIV / 2 - 1);

  logic        rx_meta, rx_sync, rx_prev;
  rx_state_t   rx_state, rx_state_nx;
  logic [BW-1:0] rx_cnt, rx_cnt_nx;
  logic [2:0]  rx_bit, rx_bit_nx;
  logic [7:0]  rx_shift, rx_shift_nx;
  logic        rx_done, rx_good, rx_bad;

  always_comb begin
    rx_state_nx = rx_state;
    rx_cnt_nx   = rx_cnt + 1'b1;
    rx_bit_nx   = rx_bit;
    rx_shift_nx = rx_shift;
    rx_done     = 1'b0;
    case (rx_state)
      RX_IDLE: begin
        rx_cnt_nx = '0;
        if (rx_prev && !rx_sync) rx_state_nx = RX_START;
      end
      RX_START: begin
        // Half a bit later the line must still be low, else it was a glitch.
        if (rx_cnt == HALF_LAST) begin
          rx_cnt_nx   = '0;
          rx_bit_nx   = '0;
          rx_state_nx = rx_sync ? RX_IDLE : RX_DATA;
        end
      end
      RX_DATA: begin
        if (rx_cnt == BAUD_LAST) begin
          rx_cnt_nx   = '0;
          rx_shift_nx = {rx_sync, rx_shift[7:1]};
          rx_bit_nx   = rx_bit + 1'b1;
          if (rx_bit == 3'd7) rx_state_nx = RX_STOP;
        end
      end
      RX_STOP: begin
        if (rx_cnt == BAUD_LAST) begin
          rx_done     = 1'b1;
          rx_state_nx = RX_IDLE;
        end
      end
      default: rx_state_nx = RX_IDLE;
    endcase
  end

  assign rx_good = rx_done && rx_sync;
  assign rx_bad  = rx_done && !rx_sync;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      rx_meta  <= 1'b1;
      rx_sync  <= 1'b1;
      rx_prev  <= 1'b1;
      rx_state <= RX_IDLE;
      rx_cnt   <= '0;
      rx_bit   <= '0;
      rx_shift <= '0;
      rx_byte  <= '0;
      rx_valid <= 1'b0;
      rx_ovf   <= 1'b0;
      rx_ferr  <= 1'b0;
    end else begin
      rx_meta  <= rx_i;
      rx_sync  <= rx_meta;
      rx_prev  <= rx_sync;
      rx_state <= rx_state_nx;
      rx_cnt   <= rx_cnt_nx;
      rx_bit   <= rx_bit_nx;
      rx_shift <= rx_shift_nx;
      if (rx_good && (!rx_valid || data_rd)) begin
        rx_byte  <= rx_shift;
        rx_valid <= 1'b1;
      end else if (data_rd) begin
        rx_valid <= 1'b0;
      end
      rx_ovf  <= (rx_ovf && !(status_wr && wdata_i[ST_RX_OVF]))
                 || (rx_good && rx_valid && !data_rd);
      rx_ferr <= (rx_ferr && !(status_wr && wdata_i[ST_RX_FERR])) || rx_bad;
    end
  end
`else
  assign rx_valid = 1'b0;
  assign rx_ovf   = 1'b0;
  assign rx_ferr  = 1'b0;
  assign rx_byte  = 8'h00;

  logic unused_rx;
  assign unused_rx = &{1'b0, rx_i, data_rd};
`endif

  // ---------------- Read port ----------------
  always_comb begin
    rd_mux = '0;
    case (reg_sel)
      REG_DATA:   rd_mux = {24'b0, rx_byte};
      REG_STATUS: begin
        rd_mux[ST_TX_FULL]  = fifo_full;
        rd_mux[ST_TX_IDLE]  = tx_idle;
        rd_mux[ST_RX_VALID] = rx_valid;
        rd_mux[ST_TX_OVF]   = tx_ovf;
        rd_mux[ST_RX_OVF]   = rx_ovf;
        rd_mux[ST_RX_FERR]  = rx_ferr;
      end
      default: rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i)     rdata_o <= '0;
    else if (rstrb_i) rdata_o <= rd_mux;
  end

endmodule

// File: tb/tb_uart_mmio.sv
// Self-checking bench for uart_mmio (DIV=4): bus register behaviour, exact TX
// line waveforms against an 8N1 frame model, overflow, reset and optional RX.
module tb_uart_mmio;

  localparam int DIV   = 4;
  localparam int FRAME = 10 * DIV;
`ifdef UART_RX_EN
  localparam bit RX_EN = 1'b1;
`else
  localparam bit RX_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] addr = '0;
  logic        rstrb = 1'b0;
  logic [31:0] rdata;
  logic [3:0]  wmask = '0;
  logic [31:0] wdata = '0;
  logic        tx;
  logic        rx = 1'b1;

  int errors = 0;
  int checks = 0;

  // Receiver-side reference state, updated from the frames the bench sends.
  bit         m_valid = 1'b0, m_ovf = 1'b0, m_ferr = 1'b0;
  logic [7:0] m_byte = 8'h00;

  logic [7:0]  burst_q[$];
  logic [63:0] cap_w;
  logic [31:0] rd;
  logic [7:0]  b1, b2, b3;
  int          low_cnt;

  uart_mmio #(.CLK_FREQ_HZ(16), .BAUD_RATE(4), .TX_FIFO_DEPTH(4)) dut (
    .clk_i   (clk),
    .rst_n_i (rst_n),
    .addr_i  (addr),
    .rstrb_i (rstrb),
    .rdata_o (rdata),
    .wmask_i (wmask),
    .wdata_i (wdata),
    .tx_o    (tx),
    .rx_i    (rx)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Line waveform of one 8N1 frame, one entry per clock, in time order.
  function automatic logic [63:0] frame_wave(input logic [7:0] b);
    logic [9:0]  bits;
    logic [63:0] w;
    bits = {1'b1, b, 1'b0};
    w = '0;
    for (int s = 0; s < FRAME; s++) w[s] = bits[s / DIV];
    return w;
  endfunction

  function automatic logic [31:0] exp_status(input bit full, input bit idle, input bit tovf);
    return {26'b0, RX_EN & m_ferr, RX_EN & m_ovf, tovf, RX_EN & m_valid, idle, full};
  endfunction

  task automatic bus_write(input logic [1:0] off, input logic [31:0] d,
                           input logic [3:0] m = 4'b0001);
    addr  = 32'h0040_0000 | (32'(off) << 2);
    wdata = d;
    wmask = m;
    @(negedge clk);
    wmask = '0;
  endtask

  task automatic bus_read(input logic [1:0] off, output logic [31:0] d);
    addr  = 32'h0040_0000 | (32'(off) << 2);
    rstrb = 1'b1;
    @(negedge clk);
    rstrb = 1'b0;
    d = rdata;
  endtask

  task automatic capture(output logic [63:0] w);
    w = '0;
    for (int s = 0; s < FRAME; s++) begin
      @(negedge clk);
      w[s] = tx;
    end
  endtask

  // Writes burst_q back-to-back and checks every frame at its exact slot.
  task automatic tx_burst(input string tag);
    fork
      begin
        foreach (burst_q[i]) bus_write(2'd0, {$urandom_range(0, 255) << 8} | 32'(burst_q[i]));
      end
      begin
        repeat (2) @(negedge clk);
        for (int f = 0; f < burst_q.size(); f++) begin
          capture(cap_w);
          check($sformatf("%s_frame%0d", tag, f), cap_w, frame_wave(burst_q[f]));
        end
      end
    join
    @(negedge clk);
    check({tag, "_line_idle"}, 64'(tx), 64'd1);
  endtask

  task automatic send_rx(input logic [7:0] b, input bit stop);
    logic [9:0] bits;
    bits = {stop, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      rx = bits[i];
      repeat (DIV) @(negedge clk);
    end
    rx = 1'b1;
    if (!stop)        m_ferr = 1'b1;
    else if (m_valid) m_ovf = 1'b1;
    else begin
      m_byte  = b;
      m_valid = 1'b1;
    end
  endtask

  initial begin
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("reset_tx", 64'(tx), 64'd1);
    check("reset_rdata", 64'(rdata), 64'd0);
    bus_read(2'd1, rd);
    check("reset_status", 64'(rd), 64'(exp_status(0, 1, 0)));

    // Single 0x55 frame: two idle cycles after the write edge, then the frame.
    fork
      bus_write(2'd0, 32'h55);
      begin
        @(negedge clk);
        check("latency_k0", 64'(tx), 64'd1);
        @(negedge clk);
        check("latency_k1", 64'(tx), 64'd1);
        capture(cap_w);
        check("frame_55", cap_w, frame_wave(8'h55));
      end
    join
    bus_read(2'd1, rd);
    check("idle_after_55", 64'(rd), 64'(exp_status(0, 1, 0)));

    // Unmapped offsets read zero and ignore writes.
    bus_write(2'd2, $urandom, 4'hF);
    bus_write(2'd3, $urandom, 4'hF);
    bus_read(2'd2, rd);
    check("read_off8", 64'(rd), 64'd0);
    bus_read(2'd3, rd);
    check("read_offc", 64'(rd), 64'd0);
    bus_read(2'd1, rd);
    check("unmapped_no_effect", 64'(rd), 64'(exp_status(0, 1, 0)));
    check("unmapped_line", 64'(tx), 64'd1);

    // Six back-to-back writes: five accepted, the sixth dropped.
    burst_q.delete();
    for (int i = 0; i < 6; i++) burst_q.push_back(8'($urandom));
    fork
      begin
        foreach (burst_q[i]) bus_write(2'd0, 32'(burst_q[i]));
        bus_read(2'd1, rd);
        check("ovf_set", 64'(rd), 64'(exp_status(1, 0, 1)));
        addr  = 32'h0040_0004;
        wdata = 32'h8;
        wmask = 4'b0001;
        rstrb = 1'b1;
        @(negedge clk);
        wmask = '0;
        rstrb = 1'b0;
        check("ovf_read_prewrite", 64'(rdata), 64'(exp_status(1, 0, 1)));
        bus_read(2'd1, rd);
        check("ovf_cleared", 64'(rd), 64'(exp_status(1, 0, 0)));
      end
      begin
        repeat (2) @(negedge clk);
        for (int f = 0; f < 5; f++) begin
          capture(cap_w);
          check($sformatf("ovf_frame%0d", f), cap_w, frame_wave(burst_q[f]));
        end
      end
    join
    @(negedge clk);
    check("ovf_line_idle", 64'(tx), 64'd1);
    check("rdata_hold", 64'(rdata), 64'(exp_status(1, 0, 0)));
    bus_read(2'd1, rd);
    check("ovf_done_status", 64'(rd), 64'(exp_status(0, 1, 0)));

    // Random bursts of 1..5 bytes never overflow and stay contiguous.
    for (int it = 0; it < 5; it++) begin
      burst_q.delete();
      for (int i = 0; i < $urandom_range(1, 5); i++) burst_q.push_back(8'($urandom));
      tx_burst($sformatf("rand%0d", it));
      bus_read(2'd1, rd);
      check($sformatf("rand%0d_status", it), 64'(rd), 64'(exp_status(0, 1, 0)));
      repeat ($urandom_range(0, 7)) @(negedge clk);
    end

    // Asynchronous reset in the middle of a frame of zeros.
    for (int i = 0; i < 5; i++) bus_write(2'd0, 32'h00);
    bus_read(2'd1, rd);
    check("pre_reset_status", 64'(rd), 64'(exp_status(1, 0, 0)));
    repeat (10) @(negedge clk);
    check("pre_reset_line_low", 64'(tx), 64'd0);
    #2 rst_n = 1'b0;
    #1;
    check("async_reset_tx", 64'(tx), 64'd1);
    check("async_reset_rdata", 64'(rdata), 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    bus_read(2'd1, rd);
    check("post_reset_status", 64'(rd), 64'(exp_status(0, 1, 0)));
    low_cnt = 0;
    repeat (FRAME + 10) begin
      @(negedge clk);
      if (tx !== 1'b1) low_cnt++;
    end
    check("post_reset_line_quiet", 64'(low_cnt), 64'd0);

    // Receive path.
    send_rx(8'hA3, 1'b1);
    repeat (2) @(negedge clk);
    bus_read(2'd1, rd);
    check("rx_valid_set", 64'(rd), 64'(exp_status(0, 1, 0)));
    bus_read(2'd0, rd);
    check("rx_data_a3", 64'(rd), RX_EN ? 64'(m_byte) : 64'd0);
    m_valid = 1'b0;
    bus_read(2'd1, rd);
    check("rx_valid_cleared", 64'(rd), 64'(exp_status(0, 1, 0)));

    b1 = 8'($urandom);
    b2 = 8'($urandom);
    send_rx(b1, 1'b1);
    send_rx(b2, 1'b1);
    repeat (2) @(negedge clk);
    bus_read(2'd1, rd);
    check("rx_ovf_set", 64'(rd), 64'(exp_status(0, 1, 0)));
    bus_read(2'd0, rd);
    check("rx_ovf_keeps_old", 64'(rd), RX_EN ? 64'(b1) : 64'd0);
    m_valid = 1'b0;
    bus_write(2'd1, 32'h10);
    m_ovf = 1'b0;
    bus_read(2'd1, rd);
    check("rx_ovf_cleared", 64'(rd), 64'(exp_status(0, 1, 0)));

    b3 = 8'($urandom);
    send_rx(b3, 1'b0);
    repeat (6) @(negedge clk);
    bus_read(2'd1, rd);
    check("rx_frame_err", 64'(rd), 64'(exp_status(0, 1, 0)));
    bus_write(2'd1, 32'h20);
    m_ferr = 1'b0;
    bus_read(2'd1, rd);
    check("rx_ferr_cleared", 64'(rd), 64'(exp_status(0, 1, 0)));

    rx = 1'b0;
    @(negedge clk);
    rx = 1'b1;
    repeat (FRAME + 4) @(negedge clk);
    bus_read(2'd1, rd);
    check("rx_glitch_ignored", 64'(rd), 64'(exp_status(0, 1, 0)));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
